// File: rtl/alu_pkg.sv
// Shared types for the iterative ALU: op encoding, FSM states and the
// helper that decides whether an op takes the multi-cycle path.
// Optional feature macro: ALU_DIV_EN (builds the restoring divider).
package alu_pkg;

  localparam int OP_W = 3;

  localparam logic [OP_W-1:0] OPC_ADD = 3'b000;
  localparam logic [OP_W-1:0] OPC_SUB = 3'b001;
  localparam logic [OP_W-1:0] OPC_MUL = 3'b010;
  localparam logic [OP_W-1:0] OPC_DIV = 3'b011;
  localparam logic [OP_W-1:0] OPC_ABS = 3'b100;
  localparam logic [OP_W-1:0] OPC_INV = 3'b101;
  localparam logic [OP_W-1:0] OPC_COM = 3'b110;
  localparam logic [OP_W-1:0] OPC_ILL = 3'b111;

  typedef enum logic [OP_W-1:0] {
    OP_ADD = OPC_ADD,
    OP_SUB = OPC_SUB,
    OP_MUL = OPC_MUL,
    OP_DIV = OPC_DIV,
    OP_ABS = OPC_ABS,
    OP_INV = OPC_INV,
    OP_COM = OPC_COM,
    OP_ILL = OPC_ILL
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_CALC = 2'b01,
    S_DONE = 2'b10
  } state_e;

  // Multi-cycle ops: MUL always, DIV only when the divider exists and the
  // divisor is nonzero (divide-by-zero is answered immediately).
  function automatic logic op_is_iter(input op_e op, input logic div_zero);
    logic iter;
    iter = 1'b0;
    if (op == OP_MUL) iter = 1'b1;
`ifdef ALU_DIV_EN
    if (op == OP_DIV && !div_zero) iter = 1'b1;
`else
    if (div_zero) iter = iter;
`endif
    return iter;
  endfunction

endpackage

// File: rtl/alu_divider.sv
// Restoring unsigned divider: one quotient bit per cycle, WIDTH cycles.
// 'done' is high during the final iteration cycle; quotient is valid after
// that edge and holds until the next start.
module alu_divider
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             done,
  output logic [WIDTH-1:0] quotient
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic             busy_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] dvs_q;

  logic [WIDTH:0]   rem_sh;
  logic             ge;
  logic [WIDTH-1:0] rem_df;
  logic [WIDTH-1:0] rem_n;

  // One restoring step: shift in the next dividend bit, trial-subtract.
  always_comb begin
    rem_sh = {rem_q, quo_q[WIDTH-1]};
    ge     = (rem_sh >= {1'b0, dvs_q});
    rem_df = rem_sh[WIDTH-1:0] - dvs_q;
    rem_n  = ge ? rem_df : rem_sh[WIDTH-1:0];
  end

  assign done     = busy_q && (cnt_q == LAST);
  assign quotient = quo_q;

  // Iteration state: load on start, step while busy, stop after last step.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
      rem_q  <= '0;
      quo_q  <= '0;
      dvs_q  <= '0;
    end else if (start) begin
      busy_q <= 1'b1;
      cnt_q  <= '0;
      rem_q  <= '0;
      quo_q  <= dividend;
      dvs_q  <= divisor;
    end else if (busy_q) begin
      rem_q <= rem_n;
      quo_q <= {quo_q[WIDTH-2:0], ge};
      cnt_q <= cnt_q + 1'b1;
      if (done) busy_q <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_iter.sv
// Iterative ALU with valid/ready request and response handshakes.
// Single-cycle ops answer one edge after accept; MUL (shift-add) and DIV
// (restoring, only when ALU_DIV_EN is defined) take WIDTH extra edges.
// Without ALU_DIV_EN, DIV is answered as an illegal op.
module alu_iter
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] operand1,
  input  logic [WIDTH-1:0] operand2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             com_lt,
  output logic             com_eq,
  output logic             com_gt,
  output logic             DIVZ,
  output logic             OVFL
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0]    LAST    = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  state_e state_q, state_d;
  op_e    op_in, op_q;
  logic   accept;
  logic   calc_last;
  logic   div_zero;

  logic [CW-1:0]    iter_cnt;
  logic [WIDTH-1:0] res_q;
  logic [WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0] prod_hi_q;
  logic [WIDTH-1:0] prod_lo_q;
  logic             ovfl_q, divz_q, lt_q, eq_q, gt_q;

  logic [WIDTH-1:0] res_1c;
  logic             ovfl_1c, divz_1c, lt_1c, eq_1c, gt_1c;
  logic [WIDTH:0]   sum_w, diff_w;
  logic [WIDTH-1:0] neg_w;

  logic [WIDTH:0]   mul_add;
  logic [WIDTH-1:0] hi_n, lo_n;

  assign op_in     = op_e'(op);
  assign in_ready  = (state_q == S_IDLE);
  assign accept    = in_valid && in_ready;
  assign div_zero  = (operand2 == '0);
  assign out_valid = (state_q == S_DONE);
  assign com_lt    = lt_q;
  assign com_eq    = eq_q;
  assign com_gt    = gt_q;
  assign DIVZ      = divz_q;
  assign OVFL      = ovfl_q;

`ifdef ALU_DIV_EN
  logic             div_start;
  logic             div_done;
  logic             div_sel_q;
  logic [WIDTH-1:0] div_quo;

  assign div_start = accept && (op_in == OP_DIV) && !div_zero;

  alu_divider #(.WIDTH(WIDTH)) u_div (
    .clk      (clk),
    .rst      (rst),
    .start    (div_start),
    .dividend (operand1),
    .divisor  (operand2),
    .done     (div_done),
    .quotient (div_quo)
  );

  assign result    = div_sel_q ? div_quo : res_q;
  assign calc_last = (op_q == OP_DIV) ? div_done : (iter_cnt == LAST);

  // Remember whether the current response comes from the divider.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         div_sel_q <= 1'b0;
    else if (accept) div_sel_q <= div_start;
  end
`else
  assign result    = res_q;
  assign calc_last = (iter_cnt == LAST);
`endif

  // Single-cycle results and flags, computed from the inputs at accept.
  always_comb begin
    res_1c  = '0;
    ovfl_1c = 1'b0;
    divz_1c = 1'b0;
    lt_1c   = 1'b0;
    eq_1c   = 1'b0;
    gt_1c   = 1'b0;
    sum_w   = {1'b0, operand1} + {1'b0, operand2};
    diff_w  = {1'b0, operand1} - {1'b0, operand2};
    neg_w   = -operand1;
    case (op_in)
      OP_ADD: begin
        res_1c  = sum_w[WIDTH-1:0];
        ovfl_1c = sum_w[WIDTH];
      end
      OP_SUB: begin
        res_1c  = diff_w[WIDTH-1:0];
        ovfl_1c = diff_w[WIDTH];
      end
`ifdef ALU_DIV_EN
      OP_DIV: begin
        if (div_zero) begin
          res_1c  = '1;
          divz_1c = 1'b1;
        end
      end
`endif
      OP_ABS: begin
        res_1c  = operand1[WIDTH-1] ? neg_w : operand1;
        ovfl_1c = (operand1 == MIN_NEG);
      end
      OP_INV: res_1c = ~operand1;
      OP_COM: begin
        if (operand1 < operand2) begin
          res_1c = '1;
          lt_1c  = 1'b1;
        end else if (operand1 > operand2) begin
          res_1c = WIDTH'(1);
          gt_1c  = 1'b1;
        end else begin
          eq_1c  = 1'b1;
        end
      end
      default: res_1c = '0;
    endcase
  end

  // One shift-add multiply step on the {hi, lo} product register.
  always_comb begin
    mul_add = {1'b0, prod_hi_q} + (prod_lo_q[0] ? {1'b0, mcand_q} : '0);
    hi_n    = mul_add[WIDTH:1];
    lo_n    = {mul_add[0], prod_lo_q[WIDTH-1:1]};
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (accept) state_d = op_is_iter(op_in, div_zero) ? S_CALC : S_DONE;
      S_CALC: if (calc_last) state_d = S_DONE;
      S_DONE: if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Operand capture, multiply iteration and response registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q      <= OP_ADD;
      iter_cnt  <= '0;
      res_q     <= '0;
      mcand_q   <= '0;
      prod_hi_q <= '0;
      prod_lo_q <= '0;
      ovfl_q    <= 1'b0;
      divz_q    <= 1'b0;
      lt_q      <= 1'b0;
      eq_q      <= 1'b0;
      gt_q      <= 1'b0;
    end else if (accept) begin
      op_q      <= op_in;
      iter_cnt  <= '0;
      res_q     <= res_1c;
      mcand_q   <= operand1;
      prod_hi_q <= '0;
      prod_lo_q <= operand2;
      ovfl_q    <= ovfl_1c;
      divz_q    <= divz_1c;
      lt_q      <= lt_1c;
      eq_q      <= eq_1c;
      gt_q      <= gt_1c;
    end else if (state_q == S_CALC) begin
      iter_cnt <= calc_last ? '0 : iter_cnt + 1'b1;
      if (op_q == OP_MUL) begin
        prod_hi_q <= hi_n;
        prod_lo_q <= lo_n;
        if (calc_last) begin
          res_q  <= lo_n;
          ovfl_q <= |hi_n;
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_iter.sv
// Directed-vector bench for alu_iter (WIDTH=32).
module tb_alu_iter;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [2:0]  op;
  logic [31:0] operand1, operand2;
  logic        out_valid, out_ready;
  logic [31:0] result;
  logic        com_lt, com_eq, com_gt, DIVZ, OVFL;

  int n_cmp = 0;
  int n_err = 0;

  alu_iter #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .operand1  (operand1),
    .operand2  (operand2),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .com_lt    (com_lt),
    .com_eq    (com_eq),
    .com_gt    (com_gt),
    .DIVZ      (DIVZ),
    .OVFL      (OVFL)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Present one request, count edges until out_valid (accept edge = 1).
  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                       output int lat);
    op = o; operand1 = a; operand2 = b; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic release_resp();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  // Full request/response with checks of result, flags and latency.
  task automatic vec(input string tag, input logic [2:0] o, input logic [31:0] a,
                     input logic [31:0] b, input logic [31:0] exp_res,
                     input logic [4:0] exp_flags, input int exp_lat);
    int lat;
    issue(o, a, b, lat);
    chk({tag, "_lat"}, 64'(lat), 64'(exp_lat));
    chk({tag, "_res"}, 64'(result), 64'(exp_res));
    chk({tag, "_flg"}, 64'({com_lt, com_eq, com_gt, DIVZ, OVFL}), 64'(exp_flags));
    release_resp();
  endtask

  int lat;

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    op = 3'd0; operand1 = '0; operand2 = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_result",    64'(result),    64'd0);
    chk("rst_flags",     64'({com_lt, com_eq, com_gt, DIVZ, OVFL}), 64'd0);
    rst = 1'b0;
    #1;
    chk("rst_in_ready",  64'(in_ready),  64'd1);

    // flags order: {lt, eq, gt, DIVZ, OVFL}
    vec("add_ovf",  3'b000, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001, 5'b00001, 1);
    vec("add_plain",3'b000, 32'd10,        32'd20,        32'd30,        5'b00000, 1);
    vec("sub_brw",  3'b001, 32'd3,         32'd5,         32'hFFFF_FFFE, 5'b00001, 1);
    vec("sub_plain",3'b001, 32'd9,         32'd4,         32'd5,         5'b00000, 1);
    vec("mul_ovf",  3'b010, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 5'b00001, 33);
    vec("mul_small",3'b010, 32'd3,         32'd5,         32'h0000_000F, 5'b00000, 33);
    vec("mul_big",  3'b010, 32'h0001_0001, 32'h0000_FFFF, 32'hFFFF_FFFF, 5'b00000, 33);
`ifdef ALU_DIV_EN
    vec("div_100_7",3'b011, 32'd100,       32'd7,         32'd14,        5'b00000, 33);
    vec("div_zero", 3'b011, 32'd5,         32'd0,         32'hFFFF_FFFF, 5'b00010, 1);
`else
    vec("div_100_7",3'b011, 32'd100,       32'd7,         32'd0,         5'b00000, 1);
    vec("div_zero", 3'b011, 32'd5,         32'd0,         32'd0,         5'b00000, 1);
`endif
    vec("com_lt",   3'b110, 32'd3,         32'd9,         32'hFFFF_FFFF, 5'b10000, 1);
    vec("com_gt",   3'b110, 32'd9,         32'd3,         32'd1,         5'b00100, 1);
    vec("com_eq",   3'b110, 32'd7,         32'd7,         32'd0,         5'b01000, 1);
    vec("abs_min",  3'b100, 32'h8000_0000, 32'd0,         32'h8000_0000, 5'b00001, 1);
    vec("abs_neg",  3'b100, 32'hFFFF_FFFB, 32'd0,         32'd5,         5'b00000, 1);
    vec("abs_pos",  3'b100, 32'd12,        32'd0,         32'd12,        5'b00000, 1);
    vec("inv",      3'b101, 32'h0F0F_00FF, 32'd0,         32'hF0F0_FF00, 5'b00000, 1);
    vec("illegal",  3'b111, 32'd123,       32'd456,       32'd0,         5'b00000, 1);

    // Response held: out_ready low for 10 cycles in DONE.
    issue(3'b010, 32'd3, 32'd5, lat);
    chk("hold_lat", 64'(lat), 64'd33);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("hold_res",   64'(result),    64'h0000_000F);
      chk("hold_rdy",   64'(in_ready),  64'd0);
      chk("hold_valid", 64'(out_valid), 64'd1);
    end
    release_resp();
    chk("hold_idle", 64'(in_ready), 64'd1);

    // Reset pulse during a multiply aborts it without a response.
    op = 3'b010; operand1 = 32'd7; operand2 = 32'd7; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    rst = 1'b1;
    #2;
    chk("abort_valid", 64'(out_valid), 64'd0);
    chk("abort_res",   64'(result),    64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("abort_rdy",   64'(in_ready),  64'd1);
    repeat (40) begin
      @(posedge clk); #1;
      if (out_valid) chk("abort_noresp", 64'(out_valid), 64'd0);
    end
    chk("abort_still_idle", 64'(in_ready), 64'd1);
    vec("post_rst_add", 3'b000, 32'd1, 32'd1, 32'd2, 5'b00000, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
